// File: rtl/prefix_adder_pipe.sv
// prefix_adder_pipe: pipelined Kogge-Stone parallel-prefix adder with
// valid/ready flow control on both sides.
//
// Operands X/Y plus cin are reduced through clog2(WIDTH) prefix levels.
// STAGES register ranks split those levels, ceil(levels/STAGES) per rank.
// The last rank holds the registered S/cout/ovf. Latency is STAGES cycles
// and bubbles collapse.
//
// Handshake: a producer transfer happens on a cycle with in_valid && in_ready.
// A consumer transfer happens on a cycle with out_valid && out_ready.
// S/cout/ovf stay stable while out_valid && !out_ready. in_ready never
// depends on in_valid.
//
// Build option: define PPA_SUB_EN to add the sub port. With sub=1 the adder
// computes X - Y: Y is inverted and the carry-in is forced to 1. The sub bit
// is captured together with its operands.
module prefix_adder_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             cin,
`ifdef PPA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int PER    = (LEVELS + STAGES - 1) / STAGES;

  // Group-generate after applying prefix levels [lo, hi) to (g, p).
  function automatic logic [WIDTH-1:0] ks_g(input logic [WIDTH-1:0] g_i,
                                            input logic [WIDTH-1:0] p_i,
                                            input int lo, input int hi);
    logic [WIDTH-1:0] g, p, g_n, p_n;
    g = g_i;
    p = p_i;
    for (int l = 0; l < LEVELS; l++) begin
      g_n = g;
      p_n = p;
      if (l >= lo && l < hi) begin
        for (int i = (1 << l); i < WIDTH; i++) begin
          g_n[i] = g[i] | (p[i] & g[i - (1 << l)]);
          p_n[i] = p[i] & p[i - (1 << l)];
        end
      end
      g = g_n;
      p = p_n;
    end
    return g;
  endfunction

  // Group-propagate after applying prefix levels [lo, hi).
  function automatic logic [WIDTH-1:0] ks_p(input logic [WIDTH-1:0] p_i,
                                            input int lo, input int hi);
    logic [WIDTH-1:0] p, p_n;
    p = p_i;
    for (int l = 0; l < LEVELS; l++) begin
      p_n = p;
      if (l >= lo && l < hi) begin
        for (int i = (1 << l); i < WIDTH; i++) begin
          p_n[i] = p[i] & p[i - (1 << l)];
        end
      end
      p = p_n;
    end
    return p;
  endfunction

  // Operand conditioning: the subtract option only touches Y and carry-in.
  logic [WIDTH-1:0] y_eff;
  logic             c_eff;
`ifdef PPA_SUB_EN
  assign y_eff = sub ? ~Y : Y;
  assign c_eff = cin | sub;
`else
  assign y_eff = Y;
  assign c_eff = cin;
`endif

  // lk_*[k] is the prefix state entering rank k.
  logic [WIDTH-1:0] lk_g  [STAGES];
  logic [WIDTH-1:0] lk_p  [STAGES];
  logic [WIDTH-1:0] lk_p0 [STAGES];
  logic             lk_c  [STAGES];

  assign lk_p0[0] = X ^ y_eff;
  assign lk_p[0]  = lk_p0[0];
  // Carry-in is folded into the bit-0 generate, so G[i:0] is the carry into bit i+1.
  assign lk_g[0]  = (X & y_eff) | {{(WIDTH-1){1'b0}}, lk_p0[0][0] & c_eff};
  assign lk_c[0]  = c_eff;

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] src_v;
  logic              room;

  // Rank k may load when it or any later rank is empty, or the consumer takes output.
  always_comb begin
    room = out_ready;
    ld   = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      room  = room | ~v_q[k];
      ld[k] = room;
    end
  end

  generate
    if (STAGES > 1) begin : g_src_multi
      assign src_v = {v_q[STAGES-2:0], in_valid};
    end else begin : g_src_single
      assign src_v = in_valid;
    end
  endgenerate

  // Valid bits shift forward on load; reset clears all of them.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) v_q[k] <= src_v[k];
      end
    end
  end

  assign in_ready  = !rst && ld[0];
  assign out_valid = v_q[STAGES-1];

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_rank
      localparam int LO     = k * PER;
      localparam int HI_RAW = (k + 1) * PER;
      localparam int HI     = (k == STAGES - 1) ? LEVELS :
                              ((HI_RAW < LEVELS) ? HI_RAW : LEVELS);

      logic             adv;
      logic [WIDTH-1:0] g_n;
      assign adv = ld[k] & src_v[k];
      assign g_n = ks_g(lk_g[k], lk_p[k], LO, HI);

      if (k < STAGES - 1) begin : g_mid
        logic [WIDTH-1:0] g_q, p_q, p0_q;
        logic             c_q;

        // Intermediate rank: capture partial prefix state only when a valid item advances.
        always_ff @(posedge clk) begin
          if (adv) begin
            g_q  <= g_n;
            p_q  <= ks_p(lk_p[k], LO, HI);
            p0_q <= lk_p0[k];
            c_q  <= lk_c[k];
          end
        end

        assign lk_g[k+1]  = g_q;
        assign lk_p[k+1]  = p_q;
        assign lk_p0[k+1] = p0_q;
        assign lk_c[k+1]  = c_q;
      end else begin : g_last
        logic [WIDTH-1:0] s_n;
        assign s_n = lk_p0[k] ^ {g_n[WIDTH-2:0], lk_c[k]};

        // Output rank: finish the prefix, form sum/carry/overflow, hold while stalled.
        always_ff @(posedge clk) begin
          if (rst) begin
            S    <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
          end else if (adv) begin
            S    <= s_n;
            cout <= g_n[WIDTH-1];
            ovf  <= g_n[WIDTH-1] ^ g_n[WIDTH-2];
          end
        end
      end
    end
  endgenerate

endmodule
